ddr_pattern_traffic_gen: RTL and testbench
==========================================

Name: ddr_pattern_traffic_gen

Overview:
Parametrised DDR traffic generator and read-back checker for memory-interface verification and bring-up.
- Writes NUM_SAMPLES beats of a selectable data pattern through the request FIFO, then reads the same addresses back.
- Compares returned read data in order against a regenerated expected stream, counting mismatches.
- Repeats for LOOPS passes and sits in the same place as the earlier fixed-pattern generator (FIFO request side plus read-data return path).

Parameters:
DATA_W, 128, write/read data width; multiple of WORD_W and of 32
WORD_W, 16, word width for incrementing pattern
ADDR_W, 27, address width
NUM_SAMPLES, 202, beats per phase (>=1)
ADDR_STRIDE, 8, address increment per beat
BASE_ADDR, 0, address of beat 0
LFSR_SEED, 32'hACE1_2468, LFSR start value (nonzero)
LOOPS, 1, write+read passes per enable; 0 = run until enable deasserts

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
enable  in  1  start/continue run; sampled in IDLE and at loop end
pattern_sel  in  2  0 incrementing, 1 LFSR, 2 walking-one, 3 alternating ones/zeros; latched on IDLE exit
write_allowed  in  1  FIFO can accept a write this cycle
read_allowed  in  1  FIFO can accept a read this cycle
writes_pending  in  1  writes still in flight to DDR
reads_pending  in  1  reads still in flight to DDR
rd_valid  in  1  read data beat returned (in request order)
rd_data  in  DATA_W  returned read data
write_req  out  1  write request, accepted same cycle
read_req  out  1  read request, accepted same cycle
write_data  out  DATA_W  write beat
address  out  ADDR_W  request address
mode  out  1  0 write phase, 1 read phase
busy  out  1  not in IDLE/DONE
done  out  1  run finished; held until enable low
err_count  out  16  mismatching beats, saturates at 16'hFFFF
first_err_idx  out  32  beat index of first mismatch; all-ones if none
loop_count  out  16  completed passes

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0 except first_err_idx = all-ones; counters and both LFSRs cleared/seeded. Reset mid-run aborts immediately with no drain.
- States: IDLE -> WRITE (enable=1) -> WDRAIN -> RST_CNTR -> READ -> RDRAIN -> LOOP_END -> WRITE or DONE.
  - WRITE: write_req = write_allowed & (wr_idx < NUM_SAMPLES), combinational from the registered state. wr_idx and write LFSR advance on each accepted write. Leave when wr_idx == NUM_SAMPLES.
  - WDRAIN: wait for writes_pending = 0.
  - RST_CNTR: one cycle; clear rd_idx and reseed the read-address path.
  - READ: read_req = read_allowed & (rd_idx < NUM_SAMPLES). Leave when all reads have been issued.
  - RDRAIN: wait until reads_pending = 0 and chk_idx == NUM_SAMPLES.
  - LOOP_END: one cycle; loop_count += 1. Go to WRITE if (LOOPS == 0 ? enable : loop_count+1 < LOOPS), else DONE.
  - DONE: done = 1; return to IDLE when enable = 0.
- Clearing: err_count and first_err_idx clear on IDLE exit only, so they accumulate across loops.
- Address: BASE_ADDR + idx*ADDR_STRIDE, truncated to ADDR_W; wrap-around is allowed. mode = 1 in RST_CNTR..RDRAIN.
- Patterns, per beat index i:
  - Incrementing: word k = (i*(DATA_W/WORD_W)+k) mod 2^WORD_W, with word 0 in the LSBs.
  - LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, state replicated across DATA_W. Advances once per beat, from LFSR_SEED at the start of each phase.
  - Walking-one: 1 << (i mod DATA_W).
  - Alternating: all-ones when i is even, zeros when odd.
- Checker:
  - On each rd_valid, compare rd_data against expected(chk_idx), then chk_idx += 1. The check-side LFSR is independent of the write side.
  - On mismatch: err_count += 1 (saturating); first_err_idx is loaded once.
  - rd_valid outside READ/RDRAIN, or with chk_idx == NUM_SAMPLES, counts as an error; first_err_idx is unaffected.
- Output timing: write_data/address are combinational from idx and state; other outputs are registered.
- Simultaneous events: a request issued and a rd_valid in the same cycle are independent. enable dropping mid-run does not abort; it is only sampled at LOOP_END/DONE.

Decomposition:
- Package ddr_tg_pkg holds:
  - state enum
  - pattern_sel codes
  - LFSR polynomial and next-state function
  - WRITE_MODE/READ_MODE constants
- Sub-module ddr_tg_pattern (inputs: idx, advance, restart, sel; output: pattern beat). Instantiated twice: write/read generation and check expectation.

Test Plan:
- NUM_SAMPLES=4, pattern 0, write_allowed=1 -> beat0 write_data = {16'd7,...,16'd0} at address 0; beat3 = {16'd31..16'd24} at address 24; 4 reads follow; ideal memory model gives err_count=0, done=1.
- Pattern 1, memory model flips bit 5 of beat 2 -> err_count=1, first_err_idx=2.
- Random write_allowed/read_allowed backpressure at 30% duty, pattern 2, NUM_SAMPLES=130 -> beat 128 = 128'd1, no duplicate or skipped addresses, err_count=0.
- writes_pending held high 10 cycles after the last write -> mode stays 0 and no read_req until it drops.
- LOOPS=3, pattern 3 -> loop_count=3, done=1, exactly 3×NUM_SAMPLES writes and reads.
- resetn asserted mid-READ -> all outputs are at reset values within the same cycle; a fresh run with enable=1 restarts cleanly from address 0.

Source files
------------

// File: rtl/ddr_tg_pkg.sv
// ddr_tg_pkg: shared types, pattern codes and LFSR step for the DDR pattern traffic generator.
package ddr_tg_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WDRAIN, S_RST_CNTR, S_READ, S_RDRAIN, S_LOOP_END, S_DONE
  } state_t;
  localparam logic [1:0] PAT_INC  = 2'd0;
  localparam logic [1:0] PAT_LFSR = 2'd1;
  localparam logic [1:0] PAT_WALK = 2'd2;
  localparam logic [1:0] PAT_ALT  = 2'd3;
  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic WRITE_MODE = 1'b0;
  localparam logic READ_MODE  = 1'b1;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/ddr_tg_pattern.sv
// ddr_tg_pattern: data beat for index idx under the selected pattern; owns the per-phase LFSR.
module ddr_tg_pattern import ddr_tg_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       idx,
  input  logic              advance,
  input  logic              restart,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] beat
);
  localparam int WPB = DATA_W / WORD_W;
  logic [31:0] lfsr;
  logic [DATA_W-1:0] inc;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= LFSR_SEED;
    else if (restart) lfsr <= LFSR_SEED;
    else if (advance) lfsr <= lfsr_next(lfsr);
  for (genvar k = 0; k < WPB; k++) begin : g_inc
    assign inc[k*WORD_W +: WORD_W] = WORD_W'(idx * WPB + k);
  end
  always_comb begin
    beat = '0;
    case (sel)
      PAT_INC:  beat = inc;
      PAT_LFSR: beat = {(DATA_W/32){lfsr}};
      PAT_WALK: beat = DATA_W'(1) << (idx % DATA_W);
      PAT_ALT:  beat = idx[0] ? '0 : '1;
      default:  beat = '0;
    endcase
  end
endmodule

// File: rtl/ddr_pattern_traffic_gen.sv
// ddr_pattern_traffic_gen: writes a pattern through the request FIFO, reads it back and
// checks the returned stream in order, for LOOPS passes.
module ddr_pattern_traffic_gen import ddr_tg_pkg::*; #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 27,
  parameter int NUM_SAMPLES = 202,
  parameter int ADDR_STRIDE = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter int LOOPS = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  input  logic              write_allowed,
  input  logic              read_allowed,
  input  logic              writes_pending,
  input  logic              reads_pending,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              write_req,
  output logic              read_req,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] address,
  output logic              mode,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [31:0]       first_err_idx,
  output logic [15:0]       loop_count
);
  localparam logic [31:0] N = 32'(NUM_SAMPLES);
  state_t state;
  logic [31:0] wr_idx, rd_idx, chk_idx, a_idx;
  logic [1:0] sel;
  logic [DATA_W-1:0] wr_beat, exp_beat;
  logic in_rd, chk_ok, miss;
  assign write_req = state == S_WRITE && write_allowed && wr_idx < N;
  assign read_req = state == S_READ && read_allowed && rd_idx < N;
  assign in_rd = state == S_READ || state == S_RDRAIN;
  assign chk_ok = rd_valid && in_rd && chk_idx < N;
  assign miss = chk_ok && rd_data != exp_beat;
  assign a_idx = state == S_READ ? rd_idx : wr_idx;
  assign write_data = state == S_WRITE ? wr_beat : '0;
  assign address = (state == S_WRITE || state == S_READ) ? BASE_ADDR + ADDR_W'(a_idx * ADDR_STRIDE) : '0;
  ddr_tg_pattern #(.DATA_W(DATA_W), .WORD_W(WORD_W), .LFSR_SEED(LFSR_SEED)) u_wr (
    .clk(clk), .resetn(resetn), .idx(wr_idx), .advance(write_req),
    .restart(state != S_WRITE), .sel(sel), .beat(wr_beat));
  ddr_tg_pattern #(.DATA_W(DATA_W), .WORD_W(WORD_W), .LFSR_SEED(LFSR_SEED)) u_chk (
    .clk(clk), .resetn(resetn), .idx(chk_idx), .advance(chk_ok),
    .restart(!in_rd), .sel(sel), .beat(exp_beat));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      chk_idx <= '0;
      sel <= PAT_INC;
      mode <= WRITE_MODE;
      busy <= 1'b0;
      done <= 1'b0;
      err_count <= '0;
      first_err_idx <= '1;
      loop_count <= '0;
    end else begin
      // Stray beats (wrong phase or beyond the last sample) count as errors too
      if (rd_valid && (!chk_ok || miss) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (miss && first_err_idx == '1) first_err_idx <= chk_idx;
      if (chk_ok) chk_idx <= chk_idx + 32'd1;
      if (write_req) wr_idx <= wr_idx + 32'd1;
      if (read_req) rd_idx <= rd_idx + 32'd1;
      case (state)
        S_IDLE: if (enable) begin
          state <= S_WRITE;
          sel <= pattern_sel;
          busy <= 1'b1;
          wr_idx <= '0;
          err_count <= '0;
          first_err_idx <= '1;
          loop_count <= '0;
        end
        S_WRITE: if (wr_idx == N) state <= S_WDRAIN;
        S_WDRAIN: if (!writes_pending) begin
          state <= S_RST_CNTR;
          mode <= READ_MODE;
        end
        S_RST_CNTR: begin
          state <= S_READ;
          rd_idx <= '0;
          chk_idx <= '0;
        end
        S_READ: if (rd_idx == N) state <= S_RDRAIN;
        S_RDRAIN: if (!reads_pending && chk_idx == N) begin
          state <= S_LOOP_END;
          mode <= WRITE_MODE;
        end
        S_LOOP_END: begin
          loop_count <= loop_count + 16'd1;
          wr_idx <= '0;
          if (LOOPS == 0 ? enable : 32'(loop_count) + 32'd1 < LOOPS) state <= S_WRITE;
          else begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        S_DONE: if (!enable) begin
          state <= S_IDLE;
          done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_pattern_traffic_gen.sv
// tb_ddr_pattern_traffic_gen: two generator instances (4 beats x 1 loop, 130 beats x 3 loops)
// driven by a memory model; every request and returned beat is checked against pattern rules.
module tb_ddr_pattern_traffic_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn[2], enable[2], write_allowed[2], read_allowed[2];
  logic writes_pending[2], reads_pending[2], rd_valid[2];
  logic [1:0] pattern_sel[2];
  logic [127:0] rd_data[2], write_data[2];
  logic write_req[2], read_req[2], mode[2], busy[2], done[2];
  logic [26:0] address[2];
  logic [15:0] err_count[2], loop_count[2];
  logic [31:0] first_err_idx[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ddr_pattern_traffic_gen #(.NUM_SAMPLES(g == 0 ? 4 : 130), .LOOPS(g == 0 ? 1 : 3)) dut (
      .clk(clk), .resetn(resetn[g]), .enable(enable[g]), .pattern_sel(pattern_sel[g]),
      .write_allowed(write_allowed[g]), .read_allowed(read_allowed[g]),
      .writes_pending(writes_pending[g]), .reads_pending(reads_pending[g]),
      .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .write_req(write_req[g]),
      .read_req(read_req[g]), .write_data(write_data[g]), .address(address[g]),
      .mode(mode[g]), .busy(busy[g]), .done(done[g]), .err_count(err_count[g]),
      .first_err_idx(first_err_idx[g]), .loop_count(loop_count[g]));
  end

  int ok = 0, total = 0;
  int wcnt[2], rcnt[2], tot_w[2], tot_r[2], wp_cnt[2], wp_hold[2], flip_beat[2], pend_i[2], exp_err[2];
  bit bp[2], pend_v[2], wp_prev[2];
  logic [26:0] pend_a[2];
  logic [31:0] exp_first[2];
  logic [1:0] psel[2];
  logic [127:0] mem [int];

  function automatic int nsam(input int d); return d == 0 ? 4 : 130; endfunction
  function automatic int nloops(input int d); return d == 0 ? 1 : 3; endfunction
  function automatic int key(input int d, input logic [26:0] a); return d * 134217728 + int'(a); endfunction

  // Beat i of pattern s, straight from the pattern rules
  function automatic logic [127:0] pat(input logic [1:0] s, input int i);
    logic [127:0] r;
    logic [31:0] l;
    r = '0;
    if (s == 2'd0) for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(i * 8 + k);
    else if (s == 2'd1) begin
      l = 32'hACE1_2468;
      for (int j = 0; j < i; j++) l = l[0] ? (l >> 1) ^ 32'h8020_0003 : l >> 1;
      r = {4{l}};
    end
    else if (s == 2'd2) r = 128'd1 << (i % 128);
    else r = (i % 2 == 0) ? '1 : '0;
    return r;
  endfunction

  task automatic check(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) ok++;
    else $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, d, act, exp);
  endtask

  task automatic drive(input int d);
    wp_prev[d] = writes_pending[d];
    if (resetn[d] && (busy[d] || done[d])) begin
      check("err_count", d, 128'(err_count[d]), 128'(exp_err[d]));
      check("first_err_idx", d, 128'(first_err_idx[d]), 128'(exp_first[d]));
    end
    rd_valid[d] = pend_v[d];
    rd_data[d] = '0;
    if (pend_v[d]) begin
      rd_data[d] = mem[key(d, pend_a[d])];
      if (pend_i[d] == flip_beat[d]) begin
        rd_data[d] = rd_data[d] ^ 128'h20;
        exp_err[d]++;
        if (exp_first[d] == '1) exp_first[d] = 32'(pend_i[d]);
      end
      pend_v[d] = 1'b0;
    end
    write_allowed[d] = bp[d] ? ($urandom_range(0, 9) < 3) : 1'b1;
    read_allowed[d] = bp[d] ? ($urandom_range(0, 9) < 3) : 1'b1;
    writes_pending[d] = wp_cnt[d] != 0;
    if (wp_cnt[d] > 0) wp_cnt[d]--;
  endtask

  task automatic sample(input int d);
    if (!resetn[d]) return;
    if (wp_prev[d]) begin
      check("mode_while_wpend", d, 128'(mode[d]), 128'(0));
      check("rreq_while_wpend", d, 128'(read_req[d]), 128'(0));
    end
    if (write_req[d]) begin
      check("wreq_allowed", d, 128'(write_allowed[d]), 128'(1));
      check("wmode", d, 128'(mode[d]), 128'(0));
      check("waddr", d, 128'(address[d]), 128'(27'(wcnt[d] * 8)));
      check("wdata", d, write_data[d], pat(psel[d], wcnt[d]));
      mem[key(d, address[d])] = write_data[d];
      wcnt[d] = (wcnt[d] + 1) % nsam(d);
      tot_w[d]++;
      wp_cnt[d] = wp_hold[d];
    end
    if (read_req[d]) begin
      check("rreq_allowed", d, 128'(read_allowed[d]), 128'(1));
      check("rmode", d, 128'(mode[d]), 128'(1));
      check("raddr", d, 128'(address[d]), 128'(27'(rcnt[d] * 8)));
      pend_v[d] = 1'b1;
      pend_a[d] = address[d];
      pend_i[d] = rcnt[d];
      rcnt[d] = (rcnt[d] + 1) % nsam(d);
      tot_r[d]++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) drive(d);
    #1;
    for (int d = 0; d < 2; d++) sample(d);
  end

  task automatic run(input int d, input logic [1:0] s, input bit b, input int hold, input int flip,
                     input int e_err, input logic [31:0] e_first);
    @(negedge clk);
    psel[d] = s; pattern_sel[d] = s; bp[d] = b; wp_hold[d] = hold; flip_beat[d] = flip;
    wcnt[d] = 0; rcnt[d] = 0; tot_w[d] = 0; tot_r[d] = 0; exp_err[d] = 0; exp_first[d] = '1;
    enable[d] = 1'b1;
    for (int c = 0; c < 30000 && !done[d]; c++) @(negedge clk);
    check("done", d, 128'(done[d]), 128'(1));
    check("busy_at_done", d, 128'(busy[d]), 128'(0));
    check("final_err", d, 128'(err_count[d]), 128'(e_err));
    check("final_first", d, 128'(first_err_idx[d]), 128'(e_first));
    check("loop_count", d, 128'(loop_count[d]), 128'(nloops(d)));
    check("total_writes", d, 128'(tot_w[d]), 128'(nsam(d) * nloops(d)));
    check("total_reads", d, 128'(tot_r[d]), 128'(nsam(d) * nloops(d)));
    enable[d] = 1'b0;
    repeat (2) @(negedge clk);
    check("done_clear", d, 128'(done[d]), 128'(0));
  endtask

  task automatic check_idle_outputs(input int d);
    check("rst_wreq", d, 128'(write_req[d]), 128'(0));
    check("rst_rreq", d, 128'(read_req[d]), 128'(0));
    check("rst_wdata", d, write_data[d], 128'(0));
    check("rst_addr", d, 128'(address[d]), 128'(0));
    check("rst_mode", d, 128'(mode[d]), 128'(0));
    check("rst_busy", d, 128'(busy[d]), 128'(0));
    check("rst_done", d, 128'(done[d]), 128'(0));
    check("rst_err", d, 128'(err_count[d]), 128'(0));
    check("rst_first", d, 128'(first_err_idx[d]), 128'(32'hFFFF_FFFF));
    check("rst_loops", d, 128'(loop_count[d]), 128'(0));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; enable[d] = 1'b0; pattern_sel[d] = 2'd0; psel[d] = 2'd0;
      write_allowed[d] = 1'b0; read_allowed[d] = 1'b0; writes_pending[d] = 1'b0;
      reads_pending[d] = 1'b0; rd_valid[d] = 1'b0; rd_data[d] = '0; bp[d] = 1'b0;
      pend_v[d] = 1'b0; pend_i[d] = 0; pend_a[d] = '0; wp_cnt[d] = 0; wp_hold[d] = 0;
      wp_prev[d] = 1'b0; flip_beat[d] = -1; exp_err[d] = 0; exp_first[d] = '1;
      wcnt[d] = 0; rcnt[d] = 0; tot_w[d] = 0; tot_r[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check_idle_outputs(d);
    resetn[0] = 1'b1; resetn[1] = 1'b1;
    // Incrementing, ideal memory
    run(0, 2'd0, 1'b0, 0, -1, 0, 32'hFFFF_FFFF);
    check("inc_beat0", 0, mem[key(0, 27'd0)], 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("inc_beat3", 0, mem[key(0, 27'd24)], 128'h001F_001E_001D_001C_001B_001A_0019_0018);
    // LFSR with bit 5 of beat 2 flipped on the way back
    run(0, 2'd1, 1'b0, 0, 2, 1, 32'd2);
    check("lfsr_beat0", 0, mem[key(0, 27'd0)], {4{32'hACE1_2468}});
    check("lfsr_beat1", 0, mem[key(0, 27'd8)], {4{32'h5670_9234}});
    check("lfsr_beat2", 0, mem[key(0, 27'd16)], {4{32'h2B38_491A}});
    // writes_pending held 10 cycles after each write
    run(0, 2'd3, 1'b0, 10, -1, 0, 32'hFFFF_FFFF);
    check("alt_beat1", 0, mem[key(0, 27'd8)], 128'd0);
    // Walking-one under 30% backpressure, three loops
    run(1, 2'd2, 1'b1, 0, -1, 0, 32'hFFFF_FFFF);
    check("walk_beat127", 1, mem[key(1, 27'd1016)], 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    check("walk_beat128", 1, mem[key(1, 27'd1024)], 128'd1);
    // Alternating, three loops
    run(1, 2'd3, 1'b0, 0, -1, 0, 32'hFFFF_FFFF);
    check("alt_beat0", 1, mem[key(1, 27'd0)], {128{1'b1}});
    // Reset in the middle of the read phase
    @(negedge clk);
    psel[0] = 2'd0; pattern_sel[0] = 2'd0; flip_beat[0] = -1; wcnt[0] = 0; rcnt[0] = 0;
    exp_err[0] = 0; exp_first[0] = '1; enable[0] = 1'b1;
    for (int c = 0; c < 2000 && rcnt[0] < 2; c++) @(negedge clk);
    check("reached_read", 0, 128'(rcnt[0] >= 2), 128'(1));
    @(negedge clk);
    #3;
    resetn[0] = 1'b0; enable[0] = 1'b0; rd_valid[0] = 1'b0; pend_v[0] = 1'b0;
    wcnt[0] = 0; rcnt[0] = 0;
    #1;
    check_idle_outputs(0);
    @(negedge clk);
    resetn[0] = 1'b1;
    run(0, 2'd0, 1'b0, 0, -1, 0, 32'hFFFF_FFFF);
    $display("%0d/%0d checks passed", ok, total);
    $finish;
  end
endmodule
